// File: rtl/ibuff_fetch_queue_pkg.sv
// Shared frontend definitions for the D1 instruction-buffer producer:
// line geometry, the queue entry layout and the straddle splice helper.
package ibuff_fetch_queue_pkg;

  localparam int LINE_BYTES = 64;
  localparam int OFF_BITS   = 6;
  localparam int LINE_W     = 512;
  localparam logic [OFF_BITS-1:0] SPLIT_OFF = 6'd62;

  typedef struct packed {
    logic [LINE_W-1:0] line;
    logic              exc;
  } ibuff_entry_t;

  // A 4-byte instruction at offset 62 takes its upper halfword from bytes 0..1 of the next line
  function automatic logic [LINE_W-1:0] splice_line(input logic [LINE_W-1:0] head_line,
                                                    input logic [LINE_W-1:0] next_line);
    return {head_line[LINE_W-1:16], next_line[15:0]};
  endfunction

endpackage

// File: rtl/ibuff_fetch_queue_chk.sv
// Invariant checker: credit accounting must never let a kept fill overflow the queue.
module ibuff_fetch_queue_chk #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input logic             clk,
  input logic             rst,
  input logic             fill_keep,
  input logic             pop,
  input logic [CNT_W-1:0] count
);

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    (fill_keep && !pop) |-> (count < CNT_W'(DEPTH)));

endmodule

// File: rtl/ibuff_line_ram.sv
// Line queue storage: one write port at the tail, two read ports at head and head+1.
module ibuff_line_ram
  import ibuff_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [PTR_W-1:0]  wr_ptr,
  input  logic [LINE_W:0]   wr_data,
  input  logic [PTR_W-1:0]  rd_ptr,
  output logic [LINE_W:0]   head_data,
  output logic [LINE_W:0]   next_data
);

  logic [LINE_W:0]  mem_q [DEPTH];
  logic [LINE_W:0]  mem_d [DEPTH];
  logic [PTR_W-1:0] next_ptr_s;

  // Write port
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_ptr] = wr_data;
    end else begin
      mem_d[wr_ptr] = mem_q[wr_ptr];
    end
  end

  // Storage register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Read ports; head+1 wraps with the pointer width
  always_comb begin
    next_ptr_s = rd_ptr + PTR_W'(1);
    head_data  = mem_q[rd_ptr];
    next_data  = mem_q[next_ptr_s];
  end

endmodule

// File: rtl/ibuff_fetch_queue.sv
// Instruction-buffer producer: credit-limited sequential line fetch, fill queue,
// PC tracking with cross-line splice, and resteer flush with stale-fill dropping.
module ibuff_fetch_queue
  import ibuff_fetch_queue_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 4,
  parameter int LINE_BITS = 512
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 resteer,
  input  logic [XLEN-1:0]      resteer_target,
  output logic                 ic_req_valid,
  output logic [XLEN-1:0]      ic_req_addr,
  input  logic                 ic_req_ready,
  input  logic                 ic_fill_valid,
  input  logic [LINE_BITS-1:0] ic_fill_data,
  input  logic                 ic_fill_exception,
  output logic                 d1_valid,
  output logic [LINE_BITS-1:0] IBuff_out,
  output logic [XLEN-1:0]      pc_out,
  output logic                 exception_out,
  input  logic                 d1_advance,
  input  logic                 d1_compressed
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [XLEN-1:0]  pc_q, pc_d, req_addr_q, req_addr_d, new_pc_s;
  logic [CNT_W-1:0] count_q, count_d, outstanding_q, outstanding_d, drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0] out_post_fill_s, drop_post_fill_s;
  logic [CNT_W:0]   credits_used_s;
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [LINE_W:0]  head_raw_s, next_raw_s;
  ibuff_entry_t     head_e_s, next_e_s;
  logic             split_s, d1_valid_s, req_valid_s, req_fire_s, adv_s, pop_s;
  logic             fill_keep_s, fill_drop_s;

  ibuff_line_ram #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_ram (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (fill_keep_s),
    .wr_ptr    (tail_q),
    .wr_data   ({ic_fill_data, ic_fill_exception}),
    .rd_ptr    (head_q),
    .head_data (head_raw_s),
    .next_data (next_raw_s)
  );

  ibuff_fetch_queue_chk #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_chk (
    .clk       (clk),
    .rst       (rst),
    .fill_keep (fill_keep_s),
    .pop       (pop_s),
    .count     (count_q)
  );

  // Output view: request credit, D1 validity and the (possibly spliced) line
  always_comb begin
    head_e_s       = head_raw_s;
    next_e_s       = next_raw_s;
    credits_used_s = {1'b0, count_q} + {1'b0, outstanding_q};
    req_valid_s    = !rst && !resteer && (credits_used_s < (CNT_W+1)'(DEPTH));
    split_s        = (pc_q[OFF_BITS-1:0] == SPLIT_OFF);
    if (resteer) begin
      d1_valid_s = 1'b0;
    end else if (split_s) begin
      d1_valid_s = (count_q >= CNT_W'(2));
    end else begin
      d1_valid_s = (count_q >= CNT_W'(1));
    end
    if (split_s) begin
      IBuff_out     = splice_line(head_e_s.line, next_e_s.line);
      exception_out = head_e_s.exc | next_e_s.exc;
    end else begin
      IBuff_out     = head_e_s.line;
      exception_out = head_e_s.exc;
    end
  end

  assign ic_req_valid = req_valid_s;
  assign ic_req_addr  = req_addr_q;
  assign d1_valid     = d1_valid_s;
  assign pc_out       = pc_q;

  // Next state; the dropped-fill count is taken after this cycle's fill retires
  always_comb begin
    req_fire_s       = req_valid_s && ic_req_ready;
    adv_s            = d1_advance && d1_valid_s;
    new_pc_s         = pc_q + (d1_compressed ? XLEN'(2) : XLEN'(4));
    pop_s            = adv_s && (new_pc_s[XLEN-1:OFF_BITS] != pc_q[XLEN-1:OFF_BITS]);
    fill_drop_s      = ic_fill_valid && (drop_cnt_q != CNT_W'(0));
    fill_keep_s      = ic_fill_valid && (drop_cnt_q == CNT_W'(0)) && !resteer;
    out_post_fill_s  = outstanding_q - CNT_W'(ic_fill_valid);
    drop_post_fill_s = drop_cnt_q - CNT_W'(fill_drop_s);
    if (resteer) begin
      pc_d          = resteer_target;
      req_addr_d    = {resteer_target[XLEN-1:OFF_BITS], {OFF_BITS{1'b0}}};
      head_d        = {PTR_W{1'b0}};
      tail_d        = {PTR_W{1'b0}};
      count_d       = {CNT_W{1'b0}};
      outstanding_d = out_post_fill_s;
      drop_cnt_d    = drop_post_fill_s + out_post_fill_s;
    end else begin
      pc_d          = adv_s ? new_pc_s : pc_q;
      req_addr_d    = req_fire_s ? (req_addr_q + XLEN'(LINE_BYTES)) : req_addr_q;
      head_d        = head_q + PTR_W'(pop_s);
      tail_d        = tail_q + PTR_W'(fill_keep_s);
      count_d       = count_q + CNT_W'(fill_keep_s) - CNT_W'(pop_s);
      outstanding_d = out_post_fill_s + CNT_W'(req_fire_s);
      drop_cnt_d    = drop_post_fill_s;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= '0;
      req_addr_q    <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      pc_q          <= pc_d;
      req_addr_q    <= req_addr_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_ibuff_fetch_queue.sv
// Scoreboard bench for ibuff_fetch_queue: request addresses and consumed D1 views
// are queued by the stimulus and popped by a negedge monitor.
module tb_ibuff_fetch_queue;

  localparam int XLEN = 32;
  localparam int DEPTH = 4;
  localparam int LB = 512;

  typedef struct packed {
    logic [31:0] pc;
    logic [15:0] lo;
    logic [7:0]  top;
    logic        exc;
  } d1_rec_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           resteer;
  logic [XLEN-1:0] resteer_target;
  logic           ic_req_valid;
  logic [XLEN-1:0] ic_req_addr;
  logic           ic_req_ready;
  logic           ic_fill_valid;
  logic [LB-1:0]  ic_fill_data;
  logic           ic_fill_exception;
  logic           d1_valid;
  logic [LB-1:0]  IBuff_out;
  logic [XLEN-1:0] pc_out;
  logic           exception_out;
  logic           d1_advance;
  logic           d1_compressed;

  logic [31:0] req_q[$];
  d1_rec_t     d1_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] mon_a;
  d1_rec_t     mon_exp, mon_got;

  ibuff_fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .LINE_BITS(LB)) dut (
    .clk               (clk),
    .rst               (rst),
    .resteer           (resteer),
    .resteer_target    (resteer_target),
    .ic_req_valid      (ic_req_valid),
    .ic_req_addr       (ic_req_addr),
    .ic_req_ready      (ic_req_ready),
    .ic_fill_valid     (ic_fill_valid),
    .ic_fill_data      (ic_fill_data),
    .ic_fill_exception (ic_fill_exception),
    .d1_valid          (d1_valid),
    .IBuff_out         (IBuff_out),
    .pc_out            (pc_out),
    .exception_out     (exception_out),
    .d1_advance        (d1_advance),
    .d1_compressed     (d1_compressed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every request handshake and every consumed D1 view is scored
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (ic_req_valid && ic_req_ready) begin
        checks++;
        if (req_q.size() == 0) begin
          errors++;
          $display("FAIL req_unexpected: got 0x%0h expected none", ic_req_addr);
        end else begin
          mon_a = req_q.pop_front();
          if (ic_req_addr !== mon_a) begin
            errors++;
            $display("FAIL req_addr: got 0x%0h expected 0x%0h", ic_req_addr, mon_a);
          end
        end
      end
      if (d1_valid && d1_advance) begin
        checks++;
        mon_got = {pc_out, IBuff_out[15:0], IBuff_out[511:504], exception_out};
        if (d1_q.size() == 0) begin
          errors++;
          $display("FAIL d1_unexpected: got pc=0x%0h expected none", pc_out);
        end else begin
          mon_exp = d1_q.pop_front();
          if (mon_got !== mon_exp) begin
            errors++;
            $display("FAIL d1_view: got pc=0x%0h lo=0x%0h top=0x%0h exc=%0d expected pc=0x%0h lo=0x%0h top=0x%0h exc=%0d",
                     mon_got.pc, mon_got.lo, mon_got.top, mon_got.exc,
                     mon_exp.pc, mon_exp.lo, mon_exp.top, mon_exp.exc);
          end
        end
      end
    end
  end

  function automatic logic [LB-1:0] mk_line(input logic [7:0] b0, input logic [7:0] b1,
                                            input logic [7:0] top);
    logic [LB-1:0] l;
    l = '0;
    l[7:0] = b0;
    l[15:8] = b1;
    l[511:504] = top;
    return l;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] top,
                      input logic exc);
    ic_fill_valid = 1'b1;
    ic_fill_data = mk_line(b0, b1, top);
    ic_fill_exception = exc;
    tick();
    ic_fill_valid = 1'b0;
    ic_fill_exception = 1'b0;
  endtask

  task automatic adv(input int n, input logic comp);
    d1_advance = 1'b1;
    d1_compressed = comp;
    repeat (n) tick();
    d1_advance = 1'b0;
    d1_compressed = 1'b0;
  endtask

  task automatic exp_run(input logic [31:0] pc0, input int n, input logic [15:0] lo,
                         input logic [7:0] top, input logic exc);
    for (int i = 0; i < n; i++) begin
      d1_q.push_back({pc0 + 32'(4 * i), lo, top, exc});
    end
  endtask

  initial begin
    rst = 1'b1;
    resteer = 1'b0;
    resteer_target = '0;
    ic_req_ready = 1'b0;
    ic_fill_valid = 1'b0;
    ic_fill_data = '0;
    ic_fill_exception = 1'b0;
    d1_advance = 1'b0;
    d1_compressed = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_valid", 64'(ic_req_valid), 64'h0);
    chk("rst_req_addr", 64'(ic_req_addr), 64'h0);
    chk("rst_d1_valid", 64'(d1_valid), 64'h0);
    chk("rst_pc", 64'(pc_out), 64'h0);
    chk("rst_exc", 64'(exception_out), 64'h0);
    chk("rst_line", 64'(IBuff_out[63:0]), 64'h0);

    // Cold start: four requests then stall on credits
    req_q.push_back(32'h00);
    req_q.push_back(32'h40);
    req_q.push_back(32'h80);
    req_q.push_back(32'hC0);
    rst = 1'b0;
    ic_req_ready = 1'b1;
    repeat (6) tick();
    chk("cold_stall", 64'(ic_req_valid), 64'h0);
    chk("cold_req_addr", 64'(ic_req_addr), 64'h100);
    chk("cold_empty", 64'(d1_valid), 64'h0);
    fill(8'h00, 8'h01, 8'h10, 1'b0);
    chk("first_valid", 64'(d1_valid), 64'h1);
    chk("first_pc", 64'(pc_out), 64'h0);
    chk("first_lo", 64'(IBuff_out[15:0]), 64'h0100);

    // Sequential consume of the whole line
    req_q.push_back(32'h100);
    exp_run(32'h0, 16, 16'h0100, 8'h10, 1'b0);
    adv(16, 1'b0);
    chk("seq_pc", 64'(pc_out), 64'h40);
    chk("seq_popped", 64'(d1_valid), 64'h0);

    // Split at offset 62
    fill(8'h40, 8'h41, 8'h21, 1'b0);
    exp_run(32'h40, 15, 16'h4140, 8'h21, 1'b0);
    adv(15, 1'b0);
    d1_q.push_back({32'h7C, 16'h4140, 8'h21, 1'b0});
    adv(1, 1'b1);
    chk("split_pc", 64'(pc_out), 64'h7E);
    chk("split_wait", 64'(d1_valid), 64'h0);
    adv(1, 1'b1);
    chk("adv_ignored", 64'(pc_out), 64'h7E);
    fill(8'hAB, 8'hCD, 8'h22, 1'b0);
    chk("split_valid", 64'(d1_valid), 64'h1);
    chk("split_lo", 64'(IBuff_out[15:0]), 64'hCDAB);
    chk("split_top", 64'(IBuff_out[511:504]), 64'h21);
    req_q.push_back(32'h140);
    d1_q.push_back({32'h7E, 16'hCDAB, 8'h21, 1'b0});
    adv(1, 1'b1);
    chk("split_pop_pc", 64'(pc_out), 64'h80);
    chk("split_pop_top", 64'(IBuff_out[511:504]), 64'h22);

    // Exception on the next line only, seen through the splice
    fill(8'hC0, 8'hC1, 8'h23, 1'b1);
    exp_run(32'h80, 15, 16'hCDAB, 8'h22, 1'b0);
    adv(15, 1'b0);
    d1_q.push_back({32'hBC, 16'hCDAB, 8'h22, 1'b0});
    adv(1, 1'b1);
    chk("exc_split_valid", 64'(d1_valid), 64'h1);
    chk("exc_split", 64'(exception_out), 64'h1);
    chk("exc_split_lo", 64'(IBuff_out[15:0]), 64'hC1C0);
    ic_req_ready = 1'b0;
    d1_q.push_back({32'hBE, 16'hC1C0, 8'h22, 1'b1});
    adv(1, 1'b1);
    chk("exc_head", 64'(exception_out), 64'h1);
    chk("exc_head_top", 64'(IBuff_out[511:504]), 64'h23);

    // Fill, popping advance and request in one cycle at count 2
    fill(8'h50, 8'h51, 8'h24, 1'b0);
    exp_run(32'hC0, 15, 16'hC1C0, 8'h23, 1'b1);
    adv(15, 1'b0);
    req_q.push_back(32'h180);
    d1_q.push_back({32'hFC, 16'hC1C0, 8'h23, 1'b1});
    ic_req_ready = 1'b1;
    ic_fill_valid = 1'b1;
    ic_fill_data = mk_line(8'h60, 8'h61, 8'h25);
    d1_advance = 1'b1;
    tick();
    ic_fill_valid = 1'b0;
    d1_advance = 1'b0;
    ic_req_ready = 1'b0;
    chk("simul_pc", 64'(pc_out), 64'h100);
    chk("simul_valid", 64'(d1_valid), 64'h1);
    chk("simul_lo", 64'(IBuff_out[15:0]), 64'h5150);
    chk("simul_credit", 64'(ic_req_valid), 64'h1);

    // Build three outstanding, then resteer
    req_q.push_back(32'h1C0);
    req_q.push_back(32'h200);
    ic_req_ready = 1'b1;
    exp_run(32'h100, 16, 16'h5150, 8'h24, 1'b0);
    adv(16, 1'b0);
    tick();
    chk("pre_rs_pc", 64'(pc_out), 64'h140);
    chk("pre_rs_lo", 64'(IBuff_out[15:0]), 64'h6160);
    resteer = 1'b1;
    resteer_target = 32'h1002;
    #1;
    chk("rs_no_req", 64'(ic_req_valid), 64'h0);
    chk("rs_no_d1", 64'(d1_valid), 64'h0);
    req_q.push_back(32'h1000);
    req_q.push_back(32'h1040);
    req_q.push_back(32'h1080);
    req_q.push_back(32'h10C0);
    tick();
    resteer = 1'b0;
    chk("rs_pc", 64'(pc_out), 64'h1002);
    chk("rs_req_addr", 64'(ic_req_addr), 64'h1000);
    chk("rs_empty", 64'(d1_valid), 64'h0);
    for (int i = 0; i < 3; i++) begin
      fill(8'hEE, 8'hEE, 8'hEE, 1'b1);
      chk("rs_drop", 64'(d1_valid), 64'h0);
    end
    fill(8'h34, 8'h12, 8'h55, 1'b0);
    chk("rs_fill_valid", 64'(d1_valid), 64'h1);
    chk("rs_fill_lo", 64'(IBuff_out[15:0]), 64'h1234);
    chk("rs_fill_exc", 64'(exception_out), 64'h0);

    // Resteer coincident with a fill
    resteer = 1'b1;
    resteer_target = 32'h2000;
    ic_fill_valid = 1'b1;
    ic_fill_data = mk_line(8'hDD, 8'hDD, 8'hDD);
    ic_fill_exception = 1'b1;
    req_q.push_back(32'h2000);
    req_q.push_back(32'h2040);
    req_q.push_back(32'h2080);
    req_q.push_back(32'h20C0);
    tick();
    resteer = 1'b0;
    ic_fill_valid = 1'b0;
    ic_fill_exception = 1'b0;
    chk("rs2_empty", 64'(d1_valid), 64'h0);
    chk("rs2_pc", 64'(pc_out), 64'h2000);
    for (int i = 0; i < 2; i++) begin
      fill(8'hEE, 8'hEE, 8'hEE, 1'b1);
      chk("rs2_drop", 64'(d1_valid), 64'h0);
    end
    fill(8'h77, 8'h66, 8'h99, 1'b0);
    chk("rs2_fill_valid", 64'(d1_valid), 64'h1);
    chk("rs2_fill_lo", 64'(IBuff_out[15:0]), 64'h6677);
    d1_q.push_back({32'h2000, 16'h6677, 8'h99, 1'b0});
    adv(1, 1'b0);
    ic_req_ready = 1'b0;
    tick();
    chk("req_q_drained", 64'(req_q.size()), 64'h0);
    chk("d1_q_drained", 64'(d1_q.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ibuff_fetch_queue.md
Name: ibuff_fetch_queue

Overview:
- Producer side of the D1 instruction-buffer interface. Issues sequential line-fetch requests to the I-cache, queues the returned 64-byte lines, and presents the D1 stage with the current line, the current fetch PC and an exception flag.
- D1 rotates the line by the low six PC bits. When an instruction straddles two lines, this block splices in bytes from the next line.
- On resteer it flushes, redirects fetch and discards in-flight stale fills.

Parameters:
- XLEN, 32, address/PC width.
- DEPTH, 4, line entries in queue (power of two, >=2).
- LINE_BITS, 512, line width (64 bytes; fixed by the D1 rotator).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- resteer  in  1  flush and redirect fetch
- resteer_target  in  XLEN  new fetch PC (halfword aligned)
- ic_req_valid  out  1  line fetch request
- ic_req_addr  out  XLEN  request address, low 6 bits zero
- ic_req_ready  in  1  I-cache accepts request
- ic_fill_valid  in  1  line returned (in request order, always accepted)
- ic_fill_data  in  LINE_BITS  line data, byte 0 in bits [7:0]
- ic_fill_exception  in  1  fetch fault for this line
- d1_valid  out  1  IBuff_out/pc_out valid
- IBuff_out  out  LINE_BITS  line presented to D1
- pc_out  out  XLEN  current fetch PC
- exception_out  out  1  fault on presented bytes
- d1_advance  in  1  D1 consumed one instruction this cycle
- d1_compressed  in  1  consumed instruction was 2 bytes (else 4)

Behaviour:
Reset values:
- pc = 0, req_addr = 0, queue empty (count = 0), outstanding = 0, drop_cnt = 0.
- All outputs 0 except ic_req_addr = 0.

Request side:
- ic_req_valid = (count + outstanding < DEPTH) && !resteer.
- A handshake (valid && ready) increments outstanding and advances req_addr by 64.
- req_addr wraps modulo 2^XLEN.

Fill side:
- Each ic_fill_valid decrements outstanding.
- If drop_cnt > 0, the fill is discarded and drop_cnt decrements.
- Otherwise the fill is written at the tail with its exception bit, and count increments.
- Credit accounting guarantees no overflow. An overflow is an assertion failure.

D1 side:
- off = pc[5:0].
- Normal case (off < 62): d1_valid = count >= 1. IBuff_out = head line; exception_out = head exc.
- Split case (off == 62): d1_valid = count >= 2. IBuff_out = head line with bytes 0..1 replaced by next-entry bytes 0..1. exception_out = head exc OR next exc.
- The split case applies even if the instruction turns out to be compressed. D1 ignores the extra bytes.
- d1_valid = 0 during the resteer cycle. pc_out always drives the pc register.

Advance:
- d1_advance is legal only when d1_valid. It is ignored otherwise.
- Step s = d1_compressed ? 2 : 4. new_pc = pc + s.
- If new_pc[XLEN-1:6] != pc[XLEN-1:6], pop the head (count decrements).
- Pop and fill in the same cycle: count unchanged; both pointers move.

Resteer (highest priority):
- Next cycle: queue empty, pc = resteer_target.
- req_addr = {resteer_target[XLEN-1:6], 6'b0}.
- drop_cnt = drop_cnt + outstanding, computed on the post-fill value for that cycle. A fill arriving in the resteer cycle is itself dropped and is not counted.
- A d1_advance in the same cycle is ignored.
- No request is issued in the resteer cycle.

Reset mid-operation clears everything asynchronously. Fills after reset are not expected.

Counters:
- outstanding and drop_cnt are clog2(DEPTH)+1 bits wide.
- Pointers are clog2(DEPTH) bits and wrap naturally.

Decomposition:
- Shared frontend package: LINE_BYTES = 64, OFF_BITS = 6, SPLIT_OFF = 62.
- Shared frontend package: typedef for a queue entry {line, exc}.
- One sub-module: ibuff_line_ram, a DEPTH x (LINE_BITS+1) register array with one write port and two read ports (head, head+1). Credits, PC and splice logic stay in the top.

Test Plan:
- Cold start: reset, ic_req_ready = 1 → requests 0x00, 0x40, 0x80, 0xC0, then stall at DEPTH=4 credits. Fill 0x00 → d1_valid, pc_out = 0.
- Sequential consume: 16 advances, d1_compressed = 0, from pc 0 → pc_out = 0x40 and head popped. One new request (0x100) is issued the cycle after the credit frees.
- Split: pc = 0x3E with only one line queued → d1_valid = 0. After the next line (bytes 0..1 = 0xAB, 0xCD) fills, IBuff_out[15:0] = 0xCDAB and d1_valid = 1. Compressed advance → pc = 0x40, pop.
- Resteer with 3 outstanding: target 0x1002 → pc_out = 0x1002, next request 0x1000. The next 3 fills are dropped; the 4th fill is presented.
- Exception: fill with ic_fill_exception = 1 → exception_out = 1 while it is head. At off = 62 with only the next line faulty → exception_out = 1.
- Simultaneous: fill, advance-with-pop and request in one cycle at count = 2 → count stays 2 and outstanding is unchanged. Also resteer coincident with a fill → that fill is dropped and queue empty.
